// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared state type, default WS2812 timing and gesture decode helpers
package ws2812_pkg;
  typedef enum logic [1:0] {IDLE, RST, SEND, DONE} ws_state_t;
  localparam int DEF_T_BIT = 60;
  localparam int DEF_T0H = 15;
  localparam int DEF_T1H = 45;
  localparam int DEF_T_RST = 15000;
  localparam int BPP = 24;
  localparam int CYC_W = 16;
  function automatic logic ges_onehot(input logic [3:0] g);
    return g != 4'd0 && (g & (g - 4'd1)) == 4'd0;
  endfunction
  function automatic logic [3:0] ges_index(input logic [3:0] g);
    return g[3] ? 4'd3 : g[2] ? 4'd2 : g[1] ? 4'd1 : 4'd0;
  endfunction
endpackage

// File: rtl/ws2812_bit_enc.sv
// ws2812_bit_enc: per-bit cycle counter and high/low encoder for one WS2812 data bit
module ws2812_bit_enc
  import ws2812_pkg::*;
#(
  parameter int T_BIT = DEF_T_BIT,
  parameter int T0H = DEF_T0H,
  parameter int T1H = DEF_T1H
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic en,
  input  logic go,
  input  logic bit_in,
  output logic dout,
  output logic bit_end
);
  localparam logic [CYC_W-1:0] LAST = CYC_W'(T_BIT - 1);
  localparam logic [CYC_W-1:0] H0 = CYC_W'(T0H);
  localparam logic [CYC_W-1:0] H1 = CYC_W'(T1H);
  logic [CYC_W-1:0] cnt_cyc, nxt_cyc;
  logic bit_q, nxt_q;
  always_comb begin
    bit_end = en && cnt_cyc == LAST;
    nxt_cyc = (en && !bit_end) ? cnt_cyc + 1'b1 : '0;
    nxt_q = (en && cnt_cyc == '0) ? bit_in : bit_q;
  end
  // dout is registered from the next-cycle counter so the pin tracks cnt_cyc without lag
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_cyc <= '0;
      bit_q <= 1'b0;
      dout <= 1'b0;
    end else begin
      cnt_cyc <= nxt_cyc;
      bit_q <= nxt_q;
      dout <= go && nxt_cyc < (nxt_q ? H1 : H0);
    end
  end
endmodule

// File: rtl/ws2812_frame_ctrl.sv
// ws2812_frame_ctrl: WS2812 frame sequencer driving the data_cfg ROM counters and the LED pin.
// WS_AUTO_REFRESH_EN: when defined, DONE loops back to RST for continuous refresh.
module ws2812_frame_ctrl
  import ws2812_pkg::*;
#(
  parameter int T_BIT = DEF_T_BIT,
  parameter int T0H = DEF_T0H,
  parameter int T1H = DEF_T1H,
  parameter int T_RST = DEF_T_RST,
  parameter int N_PIXEL = 64,
  parameter int N_IMG = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic [3:0] ges_data,
  input  logic       bit_in,
  output logic [4:0] cnt_bit,
  output logic [6:0] cnt_pixel,
  output logic [3:0] cnt_in,
  output logic       dout,
  output logic       busy,
  output logic       frame_done
);
  localparam logic [CYC_W-1:0] RST_LAST = CYC_W'(T_RST - 1);
  localparam logic [4:0] BIT_LAST = 5'(BPP - 1);
  localparam logic [6:0] PIX_LAST = 7'(N_PIXEL - 1);
  ws_state_t state, nxt;
  logic [CYC_W-1:0] cnt_rst;
  logic bit_end, last, ges_ok, latch;
  ws2812_bit_enc #(.T_BIT(T_BIT), .T0H(T0H), .T1H(T1H)) u_enc (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .en       (state == SEND),
    .go       (nxt == SEND),
    .bit_in   (bit_in),
    .dout     (dout),
    .bit_end  (bit_end)
  );
  always_comb begin
    last = bit_end && cnt_bit == BIT_LAST && cnt_pixel == PIX_LAST;
    ges_ok = ges_onehot(ges_data) && ges_index(ges_data) < 4'(N_IMG);
    nxt = state;
    case (state)
      IDLE: if (start) nxt = RST;
      RST: if (cnt_rst == RST_LAST) nxt = SEND;
      SEND: if (last) nxt = DONE;
`ifdef WS_AUTO_REFRESH_EN
      DONE: nxt = RST;
`else
      DONE: nxt = IDLE;
`endif
      default: nxt = IDLE;
    endcase
    latch = nxt == RST && state != RST;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      cnt_rst <= '0;
      cnt_bit <= '0;
      cnt_pixel <= '0;
      cnt_in <= '0;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= nxt;
      cnt_rst <= (state == RST) ? cnt_rst + 1'b1 : '0;
      busy <= nxt != IDLE;
      frame_done <= nxt == DONE;
      // image index is only sampled on frame entry so a frame never mixes images
      if (latch) begin
        cnt_bit <= '0;
        cnt_pixel <= '0;
        if (ges_ok) cnt_in <= ges_index(ges_data);
      end else if (bit_end) begin
        cnt_bit <= (cnt_bit == BIT_LAST) ? 5'd0 : cnt_bit + 5'd1;
        if (cnt_bit == BIT_LAST) cnt_pixel <= (cnt_pixel == PIX_LAST) ? 7'd0 : cnt_pixel + 7'd1;
      end
    end
  end
endmodule
